// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: RAM status codes, arbiter states and default widths for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DATA, INSTR} arb_state_t;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_ADDR_W = 32;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority I/D arbiter onto a single-port RAM; ARB_STARVE_GUARD_EN adds an instruction starvation guard
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W
`ifdef ARB_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [1:0]        ramstate,
  input  logic [WORD_W-1:0] ramload,
  output logic              mem_err
);
  arb_state_t state, nxt;
  logic dreq, pick_i, own, hit, err;
  assign dreq = dREN | dWEN;
`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve;
  assign pick_i = iREN & (!dreq | starve >= CW'(STARVE_MAX));
  always_ff @(posedge CLK)
    if (RST) starve <= '0;
    else if (state == IDLE && nxt == INSTR) starve <= '0;
    else if (state == IDLE && nxt == DATA && iREN) starve <= starve + 1'b1;
`else
  assign pick_i = iREN & !dreq;
`endif
  assign own = state == DATA ? dreq : iREN;
  assign hit = state != IDLE && ramstate == ACCESS;
  assign err = state != IDLE && ramstate == ERROR;
  assign iwait = !(hit && state == INSTR);
  assign dwait = !(hit && state == DATA);
  assign iload = ramload;
  assign dload = ramload;
  // every completion, error or withdrawal passes through IDLE before the next grant
  always_comb
    nxt = state == IDLE ? (pick_i ? INSTR : dreq ? DATA : IDLE)
        : (hit || err || !own) ? IDLE : state;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      mem_err  <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == DATA) begin
        ramaddr  <= daddr;
        ramstore <= dstore;
        ramREN   <= dREN & !dWEN;
        ramWEN   <= dWEN;
      end else if (state == IDLE && nxt == INSTR) begin
        ramaddr <= iaddr;
        ramREN  <= 1'b1;
        ramWEN  <= 1'b0;
      end else if (nxt == IDLE) begin
        ramREN <= 1'b0;
        ramWEN <= 1'b0;
      end
      if (err) mem_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: per-cycle vector table with scoreboard, plus a grant-order sequence for the starvation guard
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int F = 0, B = 1, A = 2, E = 3;
  logic CLK = 1'b0, RST = 1'b1, iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0] ramstate = 2'd0;
  logic iwait, dwait, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  always #5 CLK = ~CLK;
  mem_arbiter dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramstate(ramstate), .ramload(ramload), .mem_err(mem_err)
  );
  typedef struct packed {
    logic rst, iren, dren, dwen;
    logic [1:0] rs;
    logic [31:0] ia, da, ds, rl;
  } in_t;
  typedef struct packed {
    logic iw, dw, rr, rw, err;
    logic [31:0] addr, st;
  } out_t;
  typedef struct {
    string name;
    in_t i;
    out_t o;
  } vec_t;
  vec_t tbl[$];
  out_t sb[$];
  logic gq[$];
  int nvec = 0, nerr = 0;
  task automatic add(input string n, input int rst, ir, dr, dw, rs,
                     input logic [31:0] ia, da, ds, rl,
                     input int iw, dwt, rr, rw, er, input logic [31:0] ad, st);
    vec_t v;
    v.name = n;
    v.i = '{1'(rst), 1'(ir), 1'(dr), 1'(dw), 2'(rs), ia, da, ds, rl};
    v.o = '{1'(iw), 1'(dwt), 1'(rr), 1'(rw), 1'(er), ad, st};
    tbl.push_back(v);
  endtask
  task automatic check(input string n, input logic [31:0] rl);
    out_t e, a;
    e = sb.pop_front();
    a = '{iwait, dwait, ramREN, ramWEN, mem_err, ramaddr, ramstore};
    nvec++;
    if ({a, iload, dload} !== {e, rl, rl}) begin
      nerr++;
      $display("FAIL %s: got iw=%b dw=%b ren=%b wen=%b err=%b addr=%h st=%h il=%h dl=%h; want iw=%b dw=%b ren=%b wen=%b err=%b addr=%h st=%h ld=%h",
               n, a.iw, a.dw, a.rr, a.rw, a.err, a.addr, a.st, iload, dload,
               e.iw, e.dw, e.rr, e.rw, e.err, e.addr, e.st, rl);
    end
  endtask
  initial begin
    logic exp_i;
    int g;
    add("reset",      0, 0, 0, 0, F, 0, 0, 0, 0,                     1, 1, 0, 0, 0, 0, 0);
    add("if_req",     0, 1, 0, 0, F, 'h40, 0, 0, 0,                  1, 1, 0, 0, 0, 0, 0);
    add("if_en",      0, 1, 0, 0, B, 'h40, 0, 0, 0,                  1, 1, 1, 0, 0, 'h40, 0);
    add("if_hold",    0, 1, 0, 0, B, 'h40, 0, 0, 0,                  1, 1, 1, 0, 0, 'h40, 0);
    add("if_hit",     0, 1, 0, 0, A, 'h40, 0, 0, 'hDEADBEEF,         0, 1, 1, 0, 0, 'h40, 0);
    add("if_idle",    0, 0, 0, 0, F, 'h40, 0, 0, 0,                  1, 1, 0, 0, 0, 'h40, 0);
    add("dw_req",     0, 1, 0, 1, F, 'h44, 'h80, 'h12345678, 0,      1, 1, 0, 0, 0, 'h40, 0);
    add("dw_en",      0, 1, 0, 1, B, 'h44, 'h80, 'h12345678, 0,      1, 1, 0, 1, 0, 'h80, 'h12345678);
    add("dw_hit",     0, 1, 0, 1, A, 'h44, 'h80, 'h12345678, 'h5555, 1, 0, 0, 1, 0, 'h80, 'h12345678);
    add("dw_turn",    0, 1, 0, 0, F, 'h44, 'h80, 'h12345678, 0,      1, 1, 0, 0, 0, 'h80, 'h12345678);
    add("dw_igrant",  0, 1, 0, 0, F, 'h44, 'h80, 'h12345678, 0,      1, 1, 1, 0, 0, 'h44, 'h12345678);
    add("dw_ihit",    0, 1, 0, 0, A, 'h44, 'h80, 'h12345678, 'hCAFEF00D, 0, 1, 1, 0, 0, 'h44, 'h12345678);
    add("dw_idle",    0, 0, 0, 0, F, 'h44, 'h80, 'h12345678, 0,      1, 1, 0, 0, 0, 'h44, 'h12345678);
    add("rd_req",     0, 0, 1, 0, F, 'h44, 'h100, 0, 0,              1, 1, 0, 0, 0, 'h44, 'h12345678);
    add("rd_en",      0, 0, 1, 0, B, 'h44, 'h100, 0, 0,              1, 1, 1, 0, 0, 'h100, 0);
    add("rd_drop",    0, 0, 0, 0, B, 'h44, 'h100, 0, 0,              1, 1, 1, 0, 0, 'h100, 0);
    add("rd_idle",    0, 0, 0, 0, F, 'h44, 'h100, 0, 0,              1, 1, 0, 0, 0, 'h100, 0);
    add("rd_late",    0, 0, 0, 0, A, 'h44, 'h100, 0, 'h9999,         1, 1, 0, 0, 0, 'h100, 0);
    add("idle_err",   0, 0, 0, 0, E, 'h44, 'h100, 0, 0,              1, 1, 0, 0, 0, 'h100, 0);
    add("idle_err2",  0, 0, 0, 0, F, 'h44, 'h100, 0, 0,              1, 1, 0, 0, 0, 'h100, 0);
    add("er_req",     0, 1, 0, 0, F, 'h200, 'h100, 0, 0,             1, 1, 0, 0, 0, 'h100, 0);
    add("er_en",      0, 1, 0, 0, B, 'h200, 'h100, 0, 0,             1, 1, 1, 0, 0, 'h200, 0);
    add("er_err",     0, 1, 0, 0, E, 'h200, 'h100, 0, 0,             1, 1, 1, 0, 0, 'h200, 0);
    add("er_idle",    0, 1, 0, 0, F, 'h200, 'h100, 0, 0,             1, 1, 0, 0, 1, 'h200, 0);
    add("er_regrant", 0, 1, 0, 0, B, 'h200, 'h100, 0, 0,             1, 1, 1, 0, 1, 'h200, 0);
    add("er_hit",     0, 1, 0, 0, A, 'h200, 'h100, 0, 'h11112222,    0, 1, 1, 0, 1, 'h200, 0);
    add("er_done",    0, 0, 0, 0, F, 'h200, 'h100, 0, 0,             1, 1, 0, 0, 1, 'h200, 0);
    add("rs_req",     0, 0, 1, 0, F, 'h200, 'h300, 'hAA55, 0,        1, 1, 0, 0, 1, 'h200, 0);
    add("rs_en",      0, 0, 1, 0, B, 'h200, 'h300, 'hAA55, 0,        1, 1, 1, 0, 1, 'h300, 'hAA55);
    add("rs_assert",  1, 0, 1, 0, B, 'h200, 'h300, 'hAA55, 0,        1, 1, 1, 0, 1, 'h300, 'hAA55);
    add("rs_after",   0, 0, 1, 0, A, 'h200, 'h300, 'hAA55, 0,        1, 1, 0, 0, 0, 0, 0);
    add("rs_regrant", 0, 0, 0, 0, F, 'h200, 'h300, 'hAA55, 0,        1, 1, 1, 0, 0, 'h300, 'hAA55);
    add("rs_drop",    0, 0, 0, 0, F, 'h200, 'h300, 'hAA55, 0,        1, 1, 0, 0, 0, 'h300, 'hAA55);
    add("rw_req",     0, 0, 1, 1, F, 'h200, 'h400, 'h77, 0,          1, 1, 0, 0, 0, 'h300, 'hAA55);
    add("rw_hit",     0, 0, 1, 1, A, 'h200, 'h400, 'h77, 'h77AB,     1, 0, 0, 1, 0, 'h400, 'h77);
    add("rw_idle",    0, 0, 0, 0, F, 'h200, 'h400, 'h77, 0,          1, 1, 0, 0, 0, 'h400, 'h77);
    repeat (2) @(negedge CLK);
    foreach (tbl[k]) begin
      @(negedge CLK);
      {RST, iREN, dREN, dWEN, ramstate, iaddr, daddr, dstore, ramload} = tbl[k].i;
      sb.push_back(tbl[k].o);
      #1 check(tbl[k].name, tbl[k].i.rl);
    end
    @(negedge CLK);
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 'h600; daddr = 'h500; ramstate = 2'd0; ramload = 'h0BAD;
    @(negedge CLK);
    RST = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 10; k++) gq.push_back(k % 5 == 4);
`else
    for (int k = 0; k < 10; k++) gq.push_back(1'b0);
`endif
    g = 0;
    for (int c = 0; c < 60 && gq.size() > 0; c++) begin
      ramstate = (ramREN | ramWEN) ? 2'd2 : 2'd0;
      #1;
      if (!iwait || !dwait) begin
        exp_i = gq.pop_front();
        nvec++;
        if (!iwait == !dwait || !iwait != exp_i || ramaddr != (exp_i ? 32'h600 : 32'h500)) begin
          nerr++;
          $display("FAIL grant%0d: got iw=%b dw=%b addr=%h; want %s grant addr=%h",
                   g, iwait, dwait, ramaddr, exp_i ? "INSTR" : "DATA", exp_i ? 32'h600 : 32'h500);
        end
        g++;
      end
      @(negedge CLK);
    end
    nvec++;
    if (gq.size() != 0) begin
      nerr++;
      $display("FAIL grant_timeout: got %0d grants missing, want 0", gq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
